mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit that sits in the EX stage beside `alu`. It takes operands from the ID/EX register and owns the architectural HI/LO registers. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO with a 32-iteration shift-add / restoring-divide datapath. It raises `busy` so the hazard logic stalls IF/ID/EX until the result is in HI/LO for a later MFHI/MFLO.

## Interface
- No parameters. Operand width is fixed at 32 and HI/LO at 32 each.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request valid this cycle. Sampled only when `busy`=0.
- `op` in 3: operation code.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
  - 100 MTHI, 101 MTLO.
  - 110 and 111 are reserved; no effect.
- `rs_data` in 32: multiplicand, dividend, or MT source.
- `rt_data` in 32: multiplier or divisor.
- `busy` out 1: an operation is in flight; the pipeline must stall.
- `done` out 1: one-cycle pulse when HI/LO have just been updated by a mult/div.
- `hi` out 32: architectural HI.
- `lo` out 32: architectural LO.

## Operation
- States are IDLE, ITER and FIX. `busy` = (state != IDLE).
- **IDLE, `start`=1:**
  - MTHI/MTLO: write `rs_data` into `hi`/`lo` at that edge. Stay in IDLE. No `busy`, no `done`.
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes (absolute values for signed ops; unsigned ops pass through), the result-sign flags and the op. Clear the iteration counter and go to ITER.
  - DIV/DIVU with `rt_data`=0: go straight to FIX with the preset result HI=`rs_data`, LO=32'hFFFF_FFFF. No trap.
  - Reserved op: ignored.
- **ITER:** one iteration per cycle, 32 iterations, counter 0..31. At count 31 go to FIX.
  - Multiply: 64-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring. 33-bit partial remainder, one quotient bit per cycle.
- **FIX:** apply the sign correction, write `hi`/`lo`, pulse `done`, return to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ. HI = bits [63:32], LO = bits [31:0].
  - Signed divide: LO = quotient, negated if the signs differ. HI = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0. No overflow flag.
- `hi`/`lo` hold their previous values for the whole operation. They change only in FIX or on MTHI/MTLO.
- `start` while `busy`=1 is ignored; the pipeline guarantees it is held by the stall.
- `rst` at any time, including mid-ITER:
  - abort the operation, state=IDLE;
  - `hi`=`lo`=0, `busy`=0, `done`=0 from the following cycle.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Mult/div: `start` is sampled at edge E0.
  - `busy` is high from E0 through E33 (33 cycles).
  - `hi`/`lo` update and `done` asserts at E33.
  - `done` is high for exactly the cycle after E33.
  - A new `start` is accepted at E34.
- Divide by zero: `busy` is high from E0 to E1. Results and `done` appear at E1.
- MTHI/MTLO: zero stall. The new value is visible the cycle after E0.
- All outputs are registered. No combinational path from `start`/`op`/operands to any output.

## Structure
- `mdu_pkg` holds:
  - op code constants (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO);
  - state encoding (IDLE, ITER, FIX);
  - the iteration count constant (32).
- One sub-module, `mdu_div_step`: a combinational single restoring-divide step (33-bit trial subtract, next remainder, quotient bit).
- The multiply accumulator, counter, FSM and HI/LO registers live in `mult_div_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` is seen 34 cycles after the `start` cycle. `busy` is high for 33 cycles.
- MULT 0xFFFFFFFF (−1) × 0x00000002 → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- Divide cases:
  - DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 / 2 → LO=3, HI=1.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5 / 0 → HI=5, LO=0xFFFFFFFF. `done` one cycle after the `start` edge; `busy` high for 1 cycle.
- MTHI 0x1234 then MTLO 0xABCD on back-to-back cycles → `hi`=0x1234 and `lo`=0xABCD one cycle after each. `busy`/`done` stay 0.
- Abort and ignore cases:
  - MULT started, a second `start` (DIV) pulsed at iteration 5 → ignored; the MULT result is correct.
  - `rst` at iteration 10 of a DIV → next cycle `busy`=0, `hi`=`lo`=0. No `done` pulse.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op codes, FSM encoding,
// iteration count and the operand magnitude/negate helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int unsigned MDU_ITERS = 32;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    logic signed [31:0] s;
    s = $signed(v);
    return $unsigned(-s);
  endfunction

  // Absolute value for signed ops; unsigned ops pass through untouched.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, rs_data, rt_data, input busy, done, hi, lo);
  modport slave  (input start, op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-divide step: shift in the next dividend bit, trial-subtract
// the divisor over 33 bits and keep the difference only if it stayed positive.
module mdu_div_step (
  input  logic [31:0] rem_i,
  input  logic        dvd_bit_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic        q_o
);
  logic [31:0] shl;
  logic [32:0] trial;

  assign shl   = {rem_i[30:0], dvd_bit_i};
  assign trial = {rem_i[31], shl} - {1'b0, dvs_i};
  assign q_o   = ~trial[32];
  // A successful subtract is always below the divisor, so 32 bits suffice.
  assign rem_o = q_o ? trial[31:0] : shl;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 restoring divide owning architectural HI/LO.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_signed;
  logic        sign_diff;
  logic [32:0] mul_sum;
  logic [63:0] prod_neg;
  logic [31:0] step_rem;
  logic        step_q;

  // acc_q holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div.
  mdu_div_step u_step (
    .rem_i     (acc_q[63:32]),
    .dvd_bit_i (acc_q[31]),
    .dvs_i     (b_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign op_signed = ~bus.op[0];
  assign sign_diff = bus.rs_data[31] ^ bus.rt_data[31];
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign prod_neg  = ~acc_q + 64'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MDU_MTHI: hi_d = bus.rs_data;
            MDU_MTLO: lo_d = bus.rs_data;
            MDU_MULT, MDU_MULTU: begin
              acc_d     = {32'd0, mag32(bus.rt_data, op_signed)};
              b_d       = mag32(bus.rs_data, op_signed);
              neg_d     = op_signed & sign_diff;
              neg_rem_d = 1'b0;
              is_div_d  = 1'b0;
              cnt_d     = 5'd0;
              state_d   = S_ITER;
            end
            MDU_DIV, MDU_DIVU: begin
              is_div_d = 1'b1;
              cnt_d    = 5'd0;
              b_d      = mag32(bus.rt_data, op_signed);
              if (bus.rt_data == 32'd0) begin
                // Divide by zero skips iteration; FIX writes the preset unchanged.
                acc_d     = {bus.rs_data, 32'hFFFF_FFFF};
                neg_d     = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = S_FIX;
              end else begin
                acc_d     = {32'd0, mag32(bus.rs_data, op_signed)};
                neg_d     = op_signed & sign_diff;
                neg_rem_d = op_signed & bus.rs_data[31];
                state_d   = S_ITER;
              end
            end
            default: ;
          endcase
        end
      end
      S_ITER: begin
        acc_d = is_div_q ? {step_rem, acc_q[30:0], step_q} : {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MDU_ITERS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_q     ? neg32(acc_q[31:0])  : acc_q[31:0];
          hi_d = neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32];
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    b_q       <= b_d;
    is_div_q  <= is_div_d;
    neg_q     <= neg_d;
    neg_rem_q <= neg_rem_d;
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, MT moves, ignore and abort cases.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and waits (bounded) for done; reports edges after E0 and busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output int bcnt);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.rs_data = a;
    bus.rt_data = b;
    tick();
    bus.start = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!bus.done && cyc < 60) begin
      if (bus.busy) bcnt++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc, bcnt, dcnt;
    logic [31:0] hi_prev, lo_prev;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.rs_data = 32'd0;
    bus.rt_data = 32'd0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    tick();

    // MULTU max x max, with HI/LO hold check during the operation
    bus.start = 1'b1; bus.op = MDU_MULTU;
    bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    chk("multu_hold_hi", bus.hi, 32'd0);
    cyc = 0; bcnt = 0;
    while (!bus.done && cyc < 60) begin
      if (bus.busy) bcnt++;
      tick();
      cyc++;
    end
    chk("multu_latency", 32'(cyc), 32'd33);
    chk("multu_busy_cycles", 32'(bcnt), 32'd33);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("multu_busy_at_done", 32'(bus.busy), 32'd0);
    tick();
    chk("multu_done_width", 32'(bus.done), 32'd0);

    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, cyc, bcnt);
    chk("mult_neg_latency", 32'(cyc), 32'd33);
    chk("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", bus.lo, 32'hFFFF_FFFE);
    tick();

    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, cyc, bcnt);
    chk("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);
    tick();

    run_op(MDU_DIVU, 32'd7, 32'd2, cyc, bcnt);
    chk("divu_7_2_latency", 32'(cyc), 32'd33);
    chk("divu_7_2_lo", bus.lo, 32'd3);
    chk("divu_7_2_hi", bus.hi, 32'd1);
    tick();

    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcnt);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'd0);
    tick();

    run_op(MDU_DIVU, 32'd5, 32'd0, cyc, bcnt);
    chk("div0_latency", 32'(cyc), 32'd1);
    chk("div0_busy_cycles", 32'(bcnt), 32'd1);
    chk("div0_hi", bus.hi, 32'd5);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    tick();
    chk("div0_done_width", 32'(bus.done), 32'd0);

    // MTHI then MTLO on back-to-back edges
    bus.start = 1'b1; bus.op = MDU_MTHI; bus.rs_data = 32'h0000_1234;
    tick();
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    chk("mthi_done", 32'(bus.done), 32'd0);
    bus.op = MDU_MTLO; bus.rs_data = 32'h0000_ABCD;
    tick();
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h0000_ABCD);
    chk("mtlo_hi_kept", bus.hi, 32'h0000_1234);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    chk("mtlo_done", 32'(bus.done), 32'd0);

    // Reserved op has no effect
    bus.start = 1'b1; bus.op = 3'b110; bus.rs_data = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0;
    chk("rsvd_busy", 32'(bus.busy), 32'd0);
    chk("rsvd_hi", bus.hi, 32'h0000_1234);
    chk("rsvd_lo", bus.lo, 32'h0000_ABCD);

    // MULT -3 x 7 with a stray DIV start at iteration 5
    bus.start = 1'b1; bus.op = MDU_MULT;
    bus.rs_data = 32'hFFFF_FFFD; bus.rt_data = 32'd7;
    tick();
    bus.start = 1'b0;
    cyc = 0; bcnt = 0;
    while (!bus.done && cyc < 60) begin
      if (bus.busy) bcnt++;
      if (cyc == 5) begin
        bus.start = 1'b1; bus.op = MDU_DIV;
        bus.rs_data = 32'd100; bus.rt_data = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    chk("ign_latency", 32'(cyc), 32'd33);
    chk("ign_busy_cycles", 32'(bcnt), 32'd33);
    chk("ign_hi", bus.hi, 32'hFFFF_FFFF);
    chk("ign_lo", bus.lo, 32'hFFFF_FFEB);
    tick();

    // Reset at iteration 10 of a DIVU aborts with no done
    hi_prev = bus.hi;
    lo_prev = bus.lo;
    bus.start = 1'b1; bus.op = MDU_DIVU;
    bus.rs_data = 32'd100; bus.rt_data = 32'd7;
    tick();
    bus.start = 1'b0;
    chk("abort_hold_lo", bus.lo, lo_prev);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) dcnt++;
      tick();
    end
    chk("abort_still_hi", bus.hi, hi_prev);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    for (int i = 0; i < 30; i++) begin
      if (bus.done) dcnt++;
      tick();
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);

    run_op(MDU_DIVU, 32'd100, 32'd7, cyc, bcnt);
    chk("post_abort_latency", 32'(cyc), 32'd33);
    chk("post_abort_lo", bus.lo, 32'd14);
    chk("post_abort_hi", bus.hi, 32'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
